down_timer_16b: RTL and testbench
=================================

DOWN_TIMER_16B -- requirements
Module: down_timer_16b

Interface
REQ-001 SHALL have parameter: WIDTH, 16, counter width in bits; a multiple of 4.
REQ-002 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port: clr  in  1  synchronous active-high reset.
REQ-004 SHALL have port: cten  in  1  count enable; low freezes prescaler and counter.
REQ-005 SHALL have port: load  in  1  load load_val into counter and reload register.
REQ-006 SHALL have port: load_val  in  WIDTH  load value.
REQ-007 SHALL have port: start  in  1  begin countdown from reload register.
REQ-008 SHALL have port: stop  in  1  pause countdown.
REQ-009 SHALL have port: auto_rld  in  1  periodic mode select.
REQ-010 SHALL have port: presc  in  4  prescale; counter steps every presc+1 enabled cycles.
REQ-011 SHALL have port: cnt  out  WIDTH  current count.
REQ-012 SHALL have port: tc  out  1  one-cycle terminal-count pulse.
REQ-013 SHALL have port: busy  out  1  high while in RUN.
REQ-014 SHALL have port: done  out  1  sticky expiry flag.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; busy = (state==RUN).
REQ-016 Input priority SHALL be clr > load > stop > start.
REQ-017 load in any state SHALL set cnt and reload register to load_val, clear prescaler and done, and move to IDLE next cycle.
REQ-018 start in IDLE or DONE with reload != 0 SHALL set cnt = reload, clear prescaler and done, and enter RUN next cycle.
REQ-019 start with reload == 0 SHALL enter DONE, set done, and pulse tc on the next cycle.
REQ-020 start in RUN SHALL be ignored; start together with stop SHALL act as stop.
REQ-021 stop in RUN SHALL enter IDLE holding cnt and prescaler; a later start reloads (no resume).
REQ-022 In RUN with cten=1, prescaler SHALL increment each cycle; tick when prescaler >= presc, which clears it and decrements cnt.
REQ-023 A presc change mid-run SHALL take effect at the next compare.
REQ-024 Tick at cnt==1 with auto_rld=0 SHALL set cnt=0, enter DONE, set done, and set tc high for exactly that one following cycle.
REQ-025 Tick at cnt==1 with auto_rld=1 SHALL set cnt=reload, stay in RUN, and pulse tc one cycle; cnt never reads 0 in this mode.
REQ-026 Expiry period SHALL be reload*(presc+1) enabled cycles; tc SHALL never be high two consecutive cycles unless reload*(presc+1)==1.
REQ-027 done SHALL remain high until load, start or clr.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 clr SHALL set: cnt=0, reload=0, prescaler=0, state=IDLE, tc=0, done=0, busy=0 at the next clk edge, from any state including mid-run, with no tc pulse.

Structure
REQ-030 Package down_timer_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the WIDTH default constant.
REQ-031 Counter SHALL be WIDTH/4 cascaded instances of sub-module sc_4b_down (4-bit down slice: clk, clr, cten, ld, ld_val[3:0], out[3:0], borrow = cten & out==0).

Verification
REQ-032 Reset: clr high 2 cycles -> cnt=0, tc=0, busy=0, done=0.
REQ-033 load_val=5, presc=0, auto_rld=0, start -> cnt 5,4,3,2,1,0 one per cycle; tc single pulse with cnt=0; done=1, busy=0.
REQ-034 load_val=2, presc=3, start -> cnt steps every 4 cycles; tc 8 cycles after RUN entry.
REQ-035 load_val=3, presc=0, auto_rld=1 -> cnt 3,2,1,3,2,1...; tc every 3 cycles, busy stays 1.
REQ-036 load_val=6; cten low 4 cycles mid-run -> cnt frozen; expiry delayed exactly 4 cycles; stop+start same cycle -> IDLE, cnt held.
REQ-037 clr at cnt=7 in RUN -> cnt=0, IDLE, no tc; then start (reload=0) -> DONE, tc one pulse, done=1.

Source files
------------

// File: rtl/down_timer_pkg.sv
// Shared FSM state type and default counter width for the down timer.
package down_timer_pkg;
  localparam int WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;
endpackage

// File: rtl/sc_4b_down.sv
// One 4-bit down-counting slice; borrow requests a step from the next slice up.
module sc_4b_down (
  input  logic       clk,
  input  logic       clr,
  input  logic       cten,
  input  logic       ld,
  input  logic [3:0] ld_val,
  output logic [3:0] out,
  output logic       borrow
);
  logic [3:0] r_val;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_val <= '0;
    end else if (ld) begin
      r_val <= ld_val;
    end else if (cten) begin
      r_val <= r_val - 4'd1;
    end
  end

  assign out    = r_val;
  assign borrow = cten & (r_val == 4'd0);
endmodule

// File: rtl/down_timer_16b.sv
// Prescaled down timer with one-shot and auto-reload modes; the count lives
// in a chain of 4-bit slices driven by the IDLE/RUN/DONE controller below.
module down_timer_16b
  import down_timer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cten,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_rld,
  input  logic [3:0]       presc,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             busy,
  output logic             done
);
  localparam int NSLICE = WIDTH / 4;

  state_t            r_state;
  logic [WIDTH-1:0]  r_reload;
  logic [3:0]        r_prescCnt;
  logic              r_tc;
  logic              r_busy;
  logic              r_done;

  logic [WIDTH-1:0]  w_cnt;
  logic [WIDTH-1:0]  w_ldVal;
  logic              w_ld;
  logic              w_dec;
  logic              w_startOk;
  logic              w_run;
  logic              w_tick;
  logic              w_atOne;
  logic              w_expire;
  logic              w_unusedBorrow;
  logic [NSLICE-1:0] w_borrow;
  logic [NSLICE-1:0] w_sliceEn;

  // Stop outranks start, so a simultaneous start/stop never starts anything.
  assign w_startOk = start && !stop && (r_state != RUN);
  assign w_run     = (r_state == RUN) && cten && !load && !stop;
  assign w_tick    = w_run && (r_prescCnt >= presc);
  assign w_atOne   = (w_cnt == WIDTH'(1));
  assign w_expire  = w_tick && w_atOne;

  always_comb begin
    w_ld    = 1'b0;
    w_ldVal = r_reload;
    w_dec   = 1'b0;
    if (load) begin
      w_ld    = 1'b1;
      w_ldVal = load_val;
    end else if (w_startOk) begin
      w_ld = 1'b1;
    end else if (w_expire && auto_rld) begin
      w_ld = 1'b1;
    end else if (w_tick) begin
      w_dec = 1'b1;
    end
  end

  for (genvar g = 0; g < NSLICE; g++) begin : g_slice
    if (g == 0) begin : g_lsb
      assign w_sliceEn[g] = w_dec;
    end else begin : g_upper
      assign w_sliceEn[g] = w_borrow[g-1];
    end

    sc_4b_down u_slice (
      .clk    (clk),
      .clr    (clr),
      .cten   (w_sliceEn[g]),
      .ld     (w_ld),
      .ld_val (w_ldVal[4*g+3:4*g]),
      .out    (w_cnt[4*g+3:4*g]),
      .borrow (w_borrow[g])
    );
  end

  // The top slice's borrow would mean wrapping below zero, which the FSM never requests.
  assign w_unusedBorrow = w_borrow[NSLICE-1];

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= IDLE;
      r_reload   <= '0;
      r_prescCnt <= '0;
      r_tc       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (load) begin
        r_reload   <= load_val;
        r_prescCnt <= '0;
        r_done     <= 1'b0;
        r_state    <= IDLE;
        r_busy     <= 1'b0;
      end else if (stop && (r_state == RUN)) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else if (w_startOk) begin
        r_prescCnt <= '0;
        if (r_reload != '0) begin
          r_done  <= 1'b0;
          r_state <= RUN;
          r_busy  <= 1'b1;
        end else begin
          r_done  <= 1'b1;
          r_tc    <= 1'b1;
          r_state <= DONE;
          r_busy  <= 1'b0;
        end
      end else if (w_run) begin
        if (w_tick) begin
          r_prescCnt <= '0;
          if (w_atOne) begin
            r_tc <= 1'b1;
            if (!auto_rld) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end else begin
          r_prescCnt <= r_prescCnt + 4'd1;
        end
      end
    end
  end

  assign cnt  = w_cnt;
  assign tc   = r_tc;
  assign busy = r_busy;
  assign done = r_done;
endmodule

// File: tb/tb_down_timer_16b.sv
// Directed bench for down_timer_16b: each task drives one scenario and checks inline.
module tb_down_timer_16b;
  logic        clk = 1'b0;
  logic        clr, cten, load, start, stop, auto_rld;
  logic [15:0] load_val;
  logic [3:0]  presc;
  logic [15:0] cnt;
  logic        tc, busy, done;

  int checks = 0;
  int errors = 0;

  down_timer_16b #(.WIDTH(16)) dut (
    .clk      (clk),
    .clr      (clr),
    .cten     (cten),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .auto_rld (auto_rld),
    .presc    (presc),
    .cnt      (cnt),
    .tc       (tc),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load_val = v;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    tick();
    tick();
    checks += 4;
    if (cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_cnt got %0d expected 0", cnt); end
    if (tc !== 1'b0)   begin errors++; $display("[TB] FAIL reset_tc got %b expected 0", tc); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b expected 0", done); end
    clr = 1'b0;
  endtask

  task automatic test_oneshot();
    presc = 4'd0;
    auto_rld = 1'b0;
    do_load(16'd5);
    checks += 2;
    if (cnt !== 16'd5) begin errors++; $display("[TB] FAIL oneshot_load_cnt got %0d expected 5", cnt); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL oneshot_load_busy got %b expected 0", busy); end
    do_start();
    checks += 2;
    if (cnt !== 16'd5) begin errors++; $display("[TB] FAIL oneshot_entry_cnt got %0d expected 5", cnt); end
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL oneshot_entry_busy got %b expected 1", busy); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks += 2;
      if (cnt !== 16'(5 - k)) begin errors++; $display("[TB] FAIL oneshot_cnt step %0d got %0d expected %0d", k, cnt, 5 - k); end
      if (tc !== (k == 5))    begin errors++; $display("[TB] FAIL oneshot_tc step %0d got %b expected %b", k, tc, k == 5); end
    end
    checks += 2;
    if (done !== 1'b1) begin errors++; $display("[TB] FAIL oneshot_done got %b expected 1", done); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL oneshot_busy got %b expected 0", busy); end
    tick();
    checks += 3;
    if (tc !== 1'b0)   begin errors++; $display("[TB] FAIL oneshot_tc_after got %b expected 0", tc); end
    if (done !== 1'b1) begin errors++; $display("[TB] FAIL oneshot_done_sticky got %b expected 1", done); end
    if (cnt !== 16'd0) begin errors++; $display("[TB] FAIL oneshot_cnt_hold got %0d expected 0", cnt); end
  endtask

  task automatic test_prescale();
    int expCnt;
    presc = 4'd3;
    do_load(16'd2);
    checks += 1;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL presc_load_clears_done got %b expected 0", done); end
    do_start();
    for (int k = 1; k <= 8; k++) begin
      tick();
      expCnt = (k < 4) ? 2 : ((k < 8) ? 1 : 0);
      checks += 2;
      if (cnt !== 16'(expCnt)) begin errors++; $display("[TB] FAIL presc_cnt cycle %0d got %0d expected %0d", k, cnt, expCnt); end
      if (tc !== (k == 8))     begin errors++; $display("[TB] FAIL presc_tc cycle %0d got %b expected %b", k, tc, k == 8); end
    end
    checks += 1;
    if (done !== 1'b1) begin errors++; $display("[TB] FAIL presc_done got %b expected 1", done); end
  endtask

  task automatic test_back_to_back();
    do_start();
    checks += 4;
    if (cnt !== 16'd2) begin errors++; $display("[TB] FAIL b2b_cnt got %0d expected 2", cnt); end
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy got %b expected 1", busy); end
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done got %b expected 0", done); end
    if (tc !== 1'b0)   begin errors++; $display("[TB] FAIL b2b_tc got %b expected 0", tc); end
  endtask

  task automatic test_autoreload();
    int expCnt;
    presc = 4'd0;
    auto_rld = 1'b1;
    do_load(16'd3);
    do_start();
    for (int k = 1; k <= 9; k++) begin
      tick();
      expCnt = (k % 3 == 0) ? 3 : 3 - (k % 3);
      checks += 3;
      if (cnt !== 16'(expCnt))  begin errors++; $display("[TB] FAIL auto_cnt cycle %0d got %0d expected %0d", k, cnt, expCnt); end
      if (tc !== (k % 3 == 0))  begin errors++; $display("[TB] FAIL auto_tc cycle %0d got %b expected %b", k, tc, k % 3 == 0); end
      if (busy !== 1'b1)        begin errors++; $display("[TB] FAIL auto_busy cycle %0d got %b expected 1", k, busy); end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL auto_stop_busy got %b expected 0", busy); end
    if (cnt !== 16'd3) begin errors++; $display("[TB] FAIL auto_stop_cnt got %0d expected 3", cnt); end
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL auto_stop_done got %b expected 0", done); end
    auto_rld = 1'b0;
  endtask

  task automatic test_cten_stop();
    int expCnt;
    do_load(16'd6);
    do_start();
    for (int k = 1; k <= 10; k++) begin
      cten = !(k >= 3 && k <= 6);
      tick();
      expCnt = (k <= 2) ? 6 - k : ((k <= 6) ? 4 : 4 - (k - 6));
      checks += 2;
      if (cnt !== 16'(expCnt)) begin errors++; $display("[TB] FAIL cten_cnt cycle %0d got %0d expected %0d", k, cnt, expCnt); end
      if (tc !== (k == 10))    begin errors++; $display("[TB] FAIL cten_tc cycle %0d got %b expected %b", k, tc, k == 10); end
    end
    cten = 1'b1;
    do_load(16'd6);
    do_start();
    tick();
    tick();
    stop = 1'b1;
    start = 1'b1;
    tick();
    stop = 1'b0;
    start = 1'b0;
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL stopstart_busy got %b expected 0", busy); end
    if (cnt !== 16'd4) begin errors++; $display("[TB] FAIL stopstart_cnt got %0d expected 4", cnt); end
    tick();
    checks += 1;
    if (cnt !== 16'd4) begin errors++; $display("[TB] FAIL idle_hold_cnt got %0d expected 4", cnt); end
    do_start();
    checks += 2;
    if (cnt !== 16'd6) begin errors++; $display("[TB] FAIL restart_reload_cnt got %0d expected 6", cnt); end
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL restart_busy got %b expected 1", busy); end
  endtask

  task automatic test_clr_midrun();
    do_load(16'd9);
    do_start();
    tick();
    tick();
    checks += 1;
    if (cnt !== 16'd7) begin errors++; $display("[TB] FAIL clr_pre_cnt got %0d expected 7", cnt); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks += 4;
    if (cnt !== 16'd0) begin errors++; $display("[TB] FAIL clr_cnt got %0d expected 0", cnt); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL clr_busy got %b expected 0", busy); end
    if (tc !== 1'b0)   begin errors++; $display("[TB] FAIL clr_tc got %b expected 0", tc); end
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL clr_done got %b expected 0", done); end
    tick();
    checks += 2;
    if (tc !== 1'b0)   begin errors++; $display("[TB] FAIL clr_tc_later got %b expected 0", tc); end
    if (cnt !== 16'd0) begin errors++; $display("[TB] FAIL clr_cnt_later got %0d expected 0", cnt); end
    do_start();
    checks += 3;
    if (tc !== 1'b1)   begin errors++; $display("[TB] FAIL zero_start_tc got %b expected 1", tc); end
    if (done !== 1'b1) begin errors++; $display("[TB] FAIL zero_start_done got %b expected 1", done); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_start_busy got %b expected 0", busy); end
    tick();
    checks += 2;
    if (tc !== 1'b0)   begin errors++; $display("[TB] FAIL zero_start_tc_once got %b expected 0", tc); end
    if (done !== 1'b1) begin errors++; $display("[TB] FAIL zero_start_done_sticky got %b expected 1", done); end
  endtask

  initial begin
    clr = 1'b1;
    cten = 1'b1;
    load = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    auto_rld = 1'b0;
    load_val = 16'd0;
    presc = 4'd0;
    test_reset();
    test_oneshot();
    test_prescale();
    test_back_to_back();
    test_autoreload();
    test_cten_stop();
    test_clr_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout reached without completing tests");
    $fatal(1, "[TB] timeout");
  end
endmodule
